// File: rtl/reg_pipe_hs.sv
// -----------------------------------------------------------------------------
// reg_pipe_hs
//   Elastic pipeline register chain with a valid/ready handshake on both sides.
//   Each stage keeps its own valid bit, so an empty stage keeps accepting data
//   while the stages after it are stalled (bubble collapsing). A full pipe with
//   ReadyOut low holds every beat unchanged. CLR empties the pipe on the next
//   edge. Cnt is a registered count of the valid beats held.
//   With stages = 0 the block is a plain wire-through with no registers.
//
// Parameters
//   width    data word width in bits (>= 1)
//   stages   number of register stages (>= 0)
//
// Ports
//   CLK       in   clock, rising edge
//   RST       in   asynchronous reset, active low
//   CLR       in   synchronous flush, active high
//   ValidIn   in   upstream data valid
//   ReadyIn   out  block accepts a beat this cycle
//   DIn       in   upstream data [width]
//   ValidOut  out  last stage holds valid data
//   ReadyOut  in   downstream accepts a beat this cycle
//   DOut      out  last stage data [width]
//   Cnt       out  number of valid beats held [clog2(stages+1), min 1]
// -----------------------------------------------------------------------------
module reg_pipe_hs #(
  parameter  int width  = 8,
  parameter  int stages = 2,
  localparam int CNT_W  = (stages > 0) ? $clog2(stages + 1) : 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CLR,
  input  logic             ValidIn,
  output logic             ReadyIn,
  input  logic [width-1:0] DIn,
  output logic             ValidOut,
  input  logic             ReadyOut,
  output logic [width-1:0] DOut,
  output logic [CNT_W-1:0] Cnt
);

  if (stages == 0) begin : g_pass

    // Pure pass-through; clock and reset have no function here.
    logic w_unused;
    assign w_unused = &{1'b0, CLK, RST};

    assign ValidOut = ValidIn;
    assign DOut     = DIn;
    assign ReadyIn  = ReadyOut & ~CLR;
    assign Cnt      = '0;

  end else begin : g_pipe

    logic [stages-1:0] r_valid;
    logic [width-1:0]  r_data [stages];
    logic [CNT_W-1:0]  r_cnt;

    logic [stages:0]   w_ready;                // w_ready[k]: stage k may load
    logic [stages-1:0] w_up_valid;             // valid presented to stage k
    logic [width-1:0]  w_up_data [stages];     // data presented to stage k
    logic              w_in_hs;
    logic              w_out_hs;

    // Ready ripples back from the output: a stage can load when it is empty
    // or when the stage after it is moving on this edge.
    always_comb begin
      // NOTE: every variable written here gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      w_ready         = '0;
      w_ready[stages] = ReadyOut;
      for (int k = stages - 1; k >= 0; k--) begin
        w_ready[k] = ~r_valid[k] | w_ready[k+1];
      end
    end

    // Upstream view of each stage: the block input for stage 0, the previous
    // stage otherwise.
    always_comb begin
      w_up_valid    = '0;
      w_up_data     = '{default: '0};
      w_up_valid[0] = ValidIn;
      w_up_data[0]  = DIn;
      for (int k = 1; k < stages; k++) begin
        w_up_valid[k] = r_valid[k-1];
        w_up_data[k]  = r_data[k-1];
      end
    end

    assign ReadyIn  = w_ready[0] & ~CLR;
    assign ValidOut = r_valid[stages-1];
    assign DOut     = r_data[stages-1];
    assign Cnt      = r_cnt;

    assign w_in_hs  = ValidIn  & ReadyIn;
    assign w_out_hs = ValidOut & ReadyOut;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // stage samples the pre-edge value of its neighbour.
    always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
        r_valid <= '0;
        r_cnt   <= '0;
        // NOTE: the data stages are a handful of flops, not a RAM, and DOut
        // must read zero out of reset, so they are reset along with the valids.
        for (int k = 0; k < stages; k++) begin
          r_data[k] <= '0;
        end
      end else if (CLR) begin
        // Flush drops the contents; data registers may keep stale values
        // because nothing reads them while the valids are low.
        r_valid <= '0;
        r_cnt   <= '0;
      end else begin
        for (int k = 0; k < stages; k++) begin
          if (w_ready[k]) begin
            r_valid[k] <= w_up_valid[k];
            // Only capture real beats; a bubble leaves the old data in place.
            if (w_up_valid[k]) begin
              r_data[k] <= w_up_data[k];
            end
          end
        end

        if (w_in_hs && !w_out_hs) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end else if (!w_in_hs && w_out_hs) begin
          r_cnt <= r_cnt - CNT_W'(1);
        end
      end
    end

  end

endmodule

// File: tb/tb_reg_pipe_hs.sv
// -----------------------------------------------------------------------------
// tb_reg_pipe_hs
//   Five instances of reg_pipe_hs (stages = 0,1,2,3,4; width = 8) share one set
//   of inputs. Each instance has its own scoreboard queue: a beat is pushed when
//   its input handshake is seen and popped/compared when its output handshake
//   is seen; Cnt is compared with the queue occupancy every cycle. Directed
//   scenario tasks add their own inline checks on the instance they target.
// -----------------------------------------------------------------------------
module tb_reg_pipe_hs;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr;
  logic       valid_in;
  logic       ready_out;
  logic [7:0] din;

  logic       rin  [5];
  logic       vout [5];
  logic [7:0] dout [5];
  logic [2:0] cnt  [5];

  logic [0:0] cnt_s0;
  logic [0:0] cnt_s1;
  logic [1:0] cnt_s2;
  logic [1:0] cnt_s3;
  logic [2:0] cnt_s4;

  assign cnt[0] = {2'b00, cnt_s0};
  assign cnt[1] = {2'b00, cnt_s1};
  assign cnt[2] = {1'b0,  cnt_s2};
  assign cnt[3] = {1'b0,  cnt_s3};
  assign cnt[4] = cnt_s4;

  always #5 clk = ~clk;

  reg_pipe_hs #(.width(8), .stages(0)) u_s0 (
    .CLK(clk), .RST(rst), .CLR(clr), .ValidIn(valid_in), .ReadyIn(rin[0]),
    .DIn(din), .ValidOut(vout[0]), .ReadyOut(ready_out), .DOut(dout[0]), .Cnt(cnt_s0));
  reg_pipe_hs #(.width(8), .stages(1)) u_s1 (
    .CLK(clk), .RST(rst), .CLR(clr), .ValidIn(valid_in), .ReadyIn(rin[1]),
    .DIn(din), .ValidOut(vout[1]), .ReadyOut(ready_out), .DOut(dout[1]), .Cnt(cnt_s1));
  reg_pipe_hs #(.width(8), .stages(2)) u_s2 (
    .CLK(clk), .RST(rst), .CLR(clr), .ValidIn(valid_in), .ReadyIn(rin[2]),
    .DIn(din), .ValidOut(vout[2]), .ReadyOut(ready_out), .DOut(dout[2]), .Cnt(cnt_s2));
  reg_pipe_hs #(.width(8), .stages(3)) u_s3 (
    .CLK(clk), .RST(rst), .CLR(clr), .ValidIn(valid_in), .ReadyIn(rin[3]),
    .DIn(din), .ValidOut(vout[3]), .ReadyOut(ready_out), .DOut(dout[3]), .Cnt(cnt_s3));
  reg_pipe_hs #(.width(8), .stages(4)) u_s4 (
    .CLK(clk), .RST(rst), .CLR(clr), .ValidIn(valid_in), .ReadyIn(rin[4]),
    .DIn(din), .ValidOut(vout[4]), .ReadyOut(ready_out), .DOut(dout[4]), .Cnt(cnt_s4));

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] sbq [5][$];   // expected beats per instance
  logic [7:0] got [5][$];   // delivered beats per instance, for scenario checks

  // One clock cycle: at the falling edge (inputs stable since posedge+1) check
  // Cnt against the model, record handshakes, then return at posedge+1.
  task automatic tick();
    logic [7:0] exp_d;
    @(negedge clk);
    if (rst) begin
      for (int i = 0; i < 5; i++) begin
        n_tests++;
        if (cnt[i] !== 3'(sbq[i].size())) begin
          n_fail++;
          $display("FAIL sb_cnt s%0d: got %0d expected %0d", i, cnt[i], sbq[i].size());
        end
        if (valid_in && rin[i]) sbq[i].push_back(din);
        if (vout[i] && ready_out) begin
          n_tests++;
          got[i].push_back(dout[i]);
          if (sbq[i].size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected s%0d: got %02h expected no beat", i, dout[i]);
          end else begin
            exp_d = sbq[i].pop_front();
            if (dout[i] !== exp_d) begin
              n_fail++;
              $display("FAIL sb_data s%0d: got %02h expected %02h", i, dout[i], exp_d);
            end
          end
        end
        if (clr) sbq[i].delete();
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    valid_in  = 1'b0;
    ready_out = 1'b1;
    clr       = 1'b0;
    repeat (n) tick();
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (sbq[i].size() != 0 || cnt[i] !== 3'd0) begin
        n_fail++;
        $display("FAIL drain s%0d: got %0d beats left (cnt %0d) expected 0", i, sbq[i].size(), cnt[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; clr = 1'b0; valid_in = 1'b1; din = 8'hAA; ready_out = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 2; i < 5; i++) begin
      n_tests++;
      if (vout[i] !== 1'b0 || dout[i] !== 8'h00 || cnt[i] !== 3'd0 || rin[i] !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_state s%0d: got v=%b d=%02h c=%0d r=%b expected v=0 d=00 c=0 r=1",
                 i, vout[i], dout[i], cnt[i], rin[i]);
      end
    end
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin sbq[i].delete(); got[i].delete(); end
    tick();
    n_tests++;
    if (cnt[2] !== 3'd1 || vout[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_first_hs: got cnt=%0d v=%b expected cnt=1 v=0", cnt[2], vout[2]);
    end
    valid_in = 1'b0; ready_out = 1'b1;
    tick();
    n_tests++;
    if (vout[2] !== 1'b1 || dout[2] !== 8'hAA) begin
      n_fail++;
      $display("FAIL reset_latency: got v=%b d=%02h expected v=1 d=aa", vout[2], dout[2]);
    end
    drain(6);
  endtask

  task automatic test_streaming();
    ready_out = 1'b1;
    for (int c = 0; c < 13; c++) begin
      valid_in = (c < 10);
      din      = 8'(c + 1);
      tick();
      if (c >= 1 && c <= 10) begin
        n_tests++;
        if (vout[2] !== 1'b1 || dout[2] !== 8'(c)) begin
          n_fail++;
          $display("FAIL stream_out c%0d: got v=%b d=%02h expected v=1 d=%02h", c, vout[2], dout[2], 8'(c));
        end
      end
      if (c == 11) begin
        n_tests++;
        if (vout[2] !== 1'b0) begin
          n_fail++;
          $display("FAIL stream_end: got v=%b expected v=0", vout[2]);
        end
      end
      if (c >= 1 && c <= 9) begin
        n_tests++;
        if (cnt[2] !== 3'd2 || rin[2] !== 1'b1) begin
          n_fail++;
          $display("FAIL stream_cnt c%0d: got cnt=%0d r=%b expected cnt=2 r=1", c, cnt[2], rin[2]);
        end
      end
    end
    drain(6);
  endtask

  task automatic test_back_pressure();
    logic [7:0] vals [4];
    vals = '{8'h11, 8'h22, 8'h33, 8'h44};
    got[3].delete();
    ready_out = 1'b0;
    for (int j = 0; j < 5; j++) begin
      valid_in = 1'b1;
      din      = vals[(j < 4) ? j : 3];
      tick();
      if (j >= 2) begin
        n_tests++;
        if (cnt[3] !== 3'd3 || rin[3] !== 1'b0 || vout[3] !== 1'b1 || dout[3] !== 8'h11) begin
          n_fail++;
          $display("FAIL bp_full j%0d: got cnt=%0d r=%b v=%b d=%02h expected cnt=3 r=0 v=1 d=11",
                   j, cnt[3], rin[3], vout[3], dout[3]);
        end
      end
    end
    ready_out = 1'b1;
    tick();
    valid_in = 1'b0;
    repeat (5) tick();
    n_tests++;
    if (got[3].size() != 4) begin
      n_fail++;
      $display("FAIL bp_count: got %0d beats expected 4", got[3].size());
    end else begin
      for (int j = 0; j < 4; j++) begin
        n_tests++;
        if (got[3][j] !== vals[j]) begin
          n_fail++;
          $display("FAIL bp_order %0d: got %02h expected %02h", j, got[3][j], vals[j]);
        end
      end
    end
    drain(6);
  endtask

  task automatic test_bubble();
    got[3].delete();
    valid_in = 1'b1; din = 8'h05; ready_out = 1'b1; tick();
    valid_in = 1'b0;                               tick();
    valid_in = 1'b1; din = 8'h06; ready_out = 1'b0; tick();
    n_tests++;
    if (cnt[3] !== 3'd2 || rin[3] !== 1'b1 || dout[3] !== 8'h05) begin
      n_fail++;
      $display("FAIL bubble_accept: got cnt=%0d r=%b d=%02h expected cnt=2 r=1 d=05", cnt[3], rin[3], dout[3]);
    end
    valid_in = 1'b0; tick();
    n_tests++;
    if (cnt[3] !== 3'd2 || rin[3] !== 1'b1) begin
      n_fail++;
      $display("FAIL bubble_hold: got cnt=%0d r=%b expected cnt=2 r=1", cnt[3], rin[3]);
    end
    valid_in = 1'b1; din = 8'h07; tick();
    n_tests++;
    if (cnt[3] !== 3'd3 || rin[3] !== 1'b0) begin
      n_fail++;
      $display("FAIL bubble_full: got cnt=%0d r=%b expected cnt=3 r=0", cnt[3], rin[3]);
    end
    drain(6);
    n_tests++;
    if (got[3].size() != 3 || got[3][0] !== 8'h05 || got[3][1] !== 8'h06 || got[3][2] !== 8'h07) begin
      n_fail++;
      $display("FAIL bubble_order: got %0d beats expected 05,06,07", got[3].size());
    end
  endtask

  task automatic test_flush();
    got[2].delete();
    ready_out = 1'b0;
    valid_in = 1'b1; din = 8'hA1; tick();
    din = 8'hA2; tick();
    n_tests++;
    if (cnt[2] !== 3'd2) begin
      n_fail++;
      $display("FAIL flush_fill: got cnt=%0d expected 2", cnt[2]);
    end
    got[2].delete();
    clr = 1'b1; din = 8'h77;
    #1;
    n_tests++;
    if (rin[2] !== 1'b0 || rin[3] !== 1'b0 || vout[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_cycle: got r2=%b r3=%b v=%b expected r2=0 r3=0 v=1", rin[2], rin[3], vout[2]);
    end
    tick();
    clr = 1'b0; valid_in = 1'b0;
    #1;
    n_tests++;
    if (vout[2] !== 1'b0 || cnt[2] !== 3'd0 || cnt[3] !== 3'd0) begin
      n_fail++;
      $display("FAIL flush_after: got v=%b c2=%0d c3=%0d expected v=0 c2=0 c3=0", vout[2], cnt[2], cnt[3]);
    end
    drain(6);
    n_tests++;
    if (got[2].size() != 0) begin
      n_fail++;
      $display("FAIL flush_leak: got %0d beats after flush expected 0", got[2].size());
    end
  endtask

  task automatic test_async_reset();
    ready_out = 1'b0; clr = 1'b0;
    valid_in = 1'b1; din = 8'hB1; tick();
    din = 8'hB2; tick();
    valid_in = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    n_tests++;
    if (vout[2] !== 1'b0 || cnt[2] !== 3'd0 || dout[2] !== 8'h00 || vout[4] !== 1'b0 || cnt[4] !== 3'd0) begin
      n_fail++;
      $display("FAIL async_reset: got v2=%b c2=%0d d2=%02h v4=%b c4=%0d expected all 0",
               vout[2], cnt[2], dout[2], vout[4], cnt[4]);
    end
    rst = 1'b1;
    for (int i = 0; i < 5; i++) sbq[i].delete();
    drain(6);
  endtask

  task automatic test_random();
    for (int n = 0; n < 10000; n++) begin
      valid_in  = 1'($urandom_range(0, 1));
      din       = 8'($urandom);
      ready_out = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain(8);
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_back_pressure();
    test_bubble();
    test_flush();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL timeout: got no end of run expected finish before 3000000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/reg_pipe_hs.md
Name: reg_pipe_hs

Overview:
- Parametrised, elastic pipeline register chain with a valid/ready handshake on both sides.
- Successor to the plain pipelining register: configurable depth, per-stage valid tracking, bubble collapsing, back-pressure, synchronous flush and an occupancy counter.
- Sits between arithmetic sub-blocks (adders, multipliers) so they can be retimed and stalled without losing data.

Parameters:
- width, 8, data word width in bits (>=1)
- stages, 2, number of register stages (>=0; 0 = combinational pass-through)

Ports:
- CLK  input  1  clock, rising edge
- RST  input  1  reset, asynchronous, active-low
- CLR  input  1  synchronous flush, active-high
- ValidIn  input  1  upstream data valid
- ReadyIn  output  1  block can accept a beat this cycle
- DIn  input  width  upstream data
- ValidOut  output  1  stage stages-1 holds valid data
- ReadyOut  input  1  downstream accepts a beat this cycle
- DOut  output  width  data of the last stage
- Cnt  output  clog2(stages+1) (min 1)  number of valid beats held

Behaviour:
- Reset and clock: RST is asynchronous and active-low; CLK is the clock.
- Reset state (RST=0): all stage valid bits V[k]=0, all stage data=0, Cnt=0. Therefore ValidOut=0 and DOut=0. ReadyIn follows its combinational definition and reads 1 when CLR=0.
- Per-stage state: V[k] and D[k] for k=0..stages-1. Stage 0 is the input side.
- Ready chain (combinational):
  - r[stages] = ReadyOut
  - r[k] = !V[k] | r[k+1]
  - ReadyIn = r[0] & !CLR
- Stage update on the rising CLK edge when r[k]=1:
  - V[k] <= upstream valid (ValidIn for k=0, V[k-1] otherwise).
  - D[k] <= upstream data, loaded only when upstream valid=1. Otherwise D[k] holds its old value (data gating, no X/garbage capture).
- Stage hold: when r[k]=0, V[k] and D[k] hold.
- Bubble collapsing: an empty stage accepts even if the stages after it are stalled. A full pipe with ReadyOut=0 holds all data unchanged; nothing is dropped or duplicated.
- Throughput: one beat per cycle when ReadyOut=1.
- Latency: exactly `stages` cycles from input handshake to ValidOut in an empty, unstalled pipe.
- Handshakes:
  - Input beat transfers when ValidIn & ReadyIn.
  - Output beat transfers when ValidOut & ReadyOut.
  - ValidIn may drop without waiting for ReadyIn; the block makes no assumption on upstream stability.
- Cnt: registered counter.
  - +1 on an input handshake, -1 on an output handshake, unchanged when both or neither occur.
  - Always equals popcount(V); never exceeds `stages`; never wraps.
- CLR:
  - Synchronous. On the next edge all V[k]<=0 and Cnt<=0; data registers may hold.
  - ReadyIn is forced 0 while CLR=1, so no input beat is accepted.
  - ValidOut still reflects current contents during the CLR cycle. A downstream handshake in that cycle counts as delivered.
  - CLR takes priority over every update.
- Reset mid-operation: asynchronous return to the reset state regardless of handshakes in flight.
- stages=0: ValidOut=ValidIn, DOut=DIn, ReadyIn=ReadyOut&!CLR, Cnt=0 constant. No registers.

Test Plan:
- Reset: hold RST=0 with ValidIn=1, DIn=8'hAA, then release -> ValidOut=0, DOut=8'h00, Cnt=0 during reset; first input handshake occurs on the first edge after release.
- Streaming: stages=2, ReadyOut=1, ValidIn=1 every cycle with DIn=1,2,3,...,10 -> DOut=1 appears 2 cycles after its handshake, then one value per cycle in order; Cnt settles at 2.
- Back-pressure: stages=3, ReadyOut=0, push 0x11,0x22,0x33,0x44 -> first three accepted, Cnt=3, ReadyIn=0, 0x44 held upstream; after ReadyOut=1 the output is 0x11,0x22,0x33,0x44 with no loss or duplication.
- Bubble collapse: stages=3, inputs 0x5 then gap then 0x6, with ReadyOut=0 from cycle 2 -> 0x6 is still accepted into the empty stage; Cnt=2; ReadyIn=1 until all stages are valid.
- Flush: stages=2 holding 2 beats, assert CLR for one cycle with ValidIn=1, DIn=0x77 -> ReadyIn=0 in that cycle; afterwards ValidOut=0, Cnt=0, and 0x77 never appears at the output.
- Async reset mid-stream plus random test: pulse RST low between edges while the pipe is full -> ValidOut=0 and Cnt=0 immediately. Separately, random ValidIn/ReadyOut over 10k cycles against a scoreboard FIFO model -> ordering preserved and Cnt matches model occupancy, for stages=0,1,4.
